// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, flag levels, result bus shape.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).

`define DIV_RESULT_BUS(W) logic [2*(W)-1:0]

package div_unit_pkg;

   // FSM encodings for the divider control
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_t;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the divider.
// Latency: n/a (wires only).
// Backpressure: start_i is held by the requester until the result has been consumed.

interface div_unit_if #(parameter int WIDTH = 32);
   logic                 start_i;
   logic                 signed_i;
   logic                 annul_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   `DIV_RESULT_BUS(WIDTH) result_o;
   logic                 ready_o;
   logic                 busy_o;

   modport master (
      output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, busy_o
   );

   modport slave (
      input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
      output result_o, ready_o, busy_o
   );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the working register left, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.

module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] i_work,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [2*WIDTH:0] o_work
);
   logic [2*WIDTH:0] w_shift;
   logic [WIDTH:0]   w_diff;

   assign w_shift = i_work << 1;
   assign w_diff  = w_shift[2*WIDTH:WIDTH] - {1'b0, i_divisor};

   // Keep the difference and set the quotient bit when the trial subtract did not go negative
   always_comb begin
      o_work = w_shift;
      if (!w_diff[WIDTH]) begin
         o_work = {w_diff, w_shift[WIDTH-1:1], 1'b1};
      end
   end
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient}; DIV_EARLY_OUT_EN enables the short path when |dividend| < |divisor|.
// Latency: WIDTH+1 cycles from start, 2 cycles for divide-by-zero (and early-out when enabled).
// Backpressure: busy_o stalls upstream while working; result held in END while start_i stays high.

module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t            r_state;
   div_state_t            w_next_state;
   logic [CW-1:0]         r_cnt;
   logic [2*WIDTH:0]      r_work;
   logic [2*WIDTH:0]      w_step_work;
   logic [WIDTH-1:0]      r_divisor;
   logic                  r_neg_q;
   logic                  r_neg_r;
   `DIV_RESULT_BUS(WIDTH) r_result;
   logic                  r_ready;

   logic                  w_go;
   logic                  w_op1_neg;
   logic                  w_op2_neg;
   logic [WIDTH-1:0]      w_abs1;
   logic [WIDTH-1:0]      w_abs2;
   logic                  w_div_zero;
   logic                  w_early;
   logic                  w_last;
   logic [WIDTH-1:0]      w_quot;
   logic [WIDTH-1:0]      w_rem;
   logic [WIDTH-1:0]      w_quot_fix;
   logic [WIDTH-1:0]      w_rem_fix;

   assign w_go       = (bus.start_i == DivStart) && !bus.annul_i;
   assign w_op1_neg  = bus.signed_i & bus.opdata1_i[WIDTH-1];
   assign w_op2_neg  = bus.signed_i & bus.opdata2_i[WIDTH-1];
   assign w_abs1     = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
   assign w_abs2     = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;
   assign w_div_zero = (bus.opdata2_i == '0);
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
   // Quotient is trivially zero and remainder is the dividend itself
   assign w_early = !w_div_zero && (w_abs1 < w_abs2);
`else
   assign w_early = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_work    (r_work),
      .i_divisor (r_divisor),
      .o_work    (w_step_work)
   );

   // Sign fix-up on the final iteration; the most-negative / -1 case wraps naturally
   assign w_quot     = w_step_work[WIDTH-1:0];
   assign w_rem      = w_step_work[2*WIDTH-1:WIDTH];
   assign w_quot_fix = r_neg_q ? -w_quot : w_quot;
   assign w_rem_fix  = r_neg_r ? -w_rem  : w_rem;

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;
   // Stall is combinational so upstream freezes in the same cycle start_i is seen
   assign bus.busy_o   = rst && ((r_state == DivByZero) || (r_state == DivOn) ||
                                 ((r_state == DivFree) && (bus.start_i == DivStart)));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= DivFree;
      else      r_state <= w_next_state;
   end

   // Next-state selection; annul always returns to idle without producing a result
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DivFree: begin
            if (w_go) w_next_state = (w_div_zero || w_early) ? DivByZero : DivOn;
         end
         DivByZero: begin
            w_next_state = bus.annul_i ? DivFree : DivEnd;
         end
         DivOn: begin
            if (bus.annul_i)  w_next_state = DivFree;
            else if (w_last)  w_next_state = DivEnd;
         end
         DivEnd: begin
            if (bus.annul_i || (bus.start_i == DivStop)) w_next_state = DivFree;
         end
         default: w_next_state = DivFree;
      endcase
   end

   // Operand capture, iteration, and registered result/ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_result  <= '0;
         r_ready   <= DivResultNotReady;
      end else begin
         case (r_state)
            DivFree: begin
               r_ready <= DivResultNotReady;
               r_cnt   <= '0;
               if (w_go) begin
                  r_work    <= {{(WIDTH+1){1'b0}}, w_abs1};
                  r_divisor <= w_abs2;
                  r_neg_q   <= w_op1_neg ^ w_op2_neg;
                  r_neg_r   <= w_op1_neg;
                  // Short paths produce their result here: zero, or the untouched dividend
                  r_result  <= w_early ? {bus.opdata1_i, {WIDTH{1'b0}}} : '0;
               end
            end
            DivByZero: begin
               r_ready <= bus.annul_i ? DivResultNotReady : DivResultReady;
            end
            DivOn: begin
               if (bus.annul_i) begin
                  r_ready <= DivResultNotReady;
               end else begin
                  r_work <= w_step_work;
                  r_cnt  <= r_cnt + CW'(1);
                  if (w_last) begin
                     r_result <= {w_rem_fix, w_quot_fix};
                     r_ready  <= DivResultReady;
                  end
               end
            end
            DivEnd: begin
               if (bus.annul_i || (bus.start_i == DivStop)) r_ready <= DivResultNotReady;
            end
            default: r_ready <= DivResultNotReady;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (WIDTH = 32) with an expected-result queue.
// Latency: checks ready_o timing against start_i for each operation.
// Backpressure: holds start_i through END, then releases it.

module tb_div_unit;
   localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 2;
`else
   localparam int EARLY_LAT = W + 1;
`endif

   typedef struct {
      logic [63:0] res;
      int          lat;
      string       tag;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   n_cmp;
   int   n_err;
   logic busy_tr [0:7];

   div_unit_if #(.WIDTH(W)) bus ();

   div_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one division, wait for ready_o, compare against the queued expectation
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp_res, input int exp_lat, input string tag);
      exp_t e;
      int   cyc;
      logic got;
      e.res = exp_res;
      e.lat = exp_lat;
      e.tag = tag;
      sb.push_back(e);
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      bus.signed_i  = sgn;
      bus.start_i   = 1'b1;
      #1;
      busy_tr[0] = bus.busy_o;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 100) begin
         tick();
         cyc++;
         if (cyc < 8) busy_tr[cyc] = bus.busy_o;
         if (bus.ready_o === 1'b1) got = 1'b1;
      end
      e = sb.pop_front();
      chk({e.tag, "_ready"}, {63'd0, got}, 64'd1);
      if (got) begin
         chk({e.tag, "_result"}, bus.result_o, e.res);
         chk({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
         tick();
         chk({e.tag, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, e.res[62:0]});
      end
      bus.start_i = 1'b0;
      tick();
      chk({e.tag, "_ready_drop"}, {63'd0, bus.ready_o}, 64'd0);
   endtask

   initial begin
      int seen;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus.start_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.annul_i   = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      repeat (3) tick();
      chk("reset_ready",  {63'd0, bus.ready_o}, 64'd0);
      chk("reset_result", bus.result_o, 64'd0);
      chk("reset_busy",   {63'd0, bus.busy_o}, 64'd0);
      rst = 1'b1;
      tick();

      do_op(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, W + 1, "u100_7");
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, W + 1, "s_m7_2");
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, W + 1, "s_ovf");
      do_op(32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, W + 1, "s_m100_7");
      do_op(32'd100, 32'hFFFFFFF9, 1'b1, {32'h2, 32'hFFFFFFF2}, W + 1, "s_100_m7");
      do_op(32'hFFFFFFFF, 32'h10, 1'b0, {32'hF, 32'h0FFFFFFF}, W + 1, "u_big");

      do_op(32'h12345678, 32'd0, 1'b0, 64'd0, 2, "divzero");
      chk("divzero_busy_c0", {63'd0, busy_tr[0]}, 64'd1);
      chk("divzero_busy_c1", {63'd0, busy_tr[1]}, 64'd1);
      chk("divzero_busy_c2", {63'd0, busy_tr[2]}, 64'd0);

      // Annul in cycle 10 of the iteration: no result, unit back to idle
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      bus.signed_i  = 1'b0;
      bus.start_i   = 1'b1;
      repeat (10) tick();
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      tick();
      bus.annul_i = 1'b0;
      #1;
      chk("annul_busy_idle", {63'd0, bus.busy_o}, 64'd0);
      seen = 0;
      repeat (40) begin
         tick();
         if (bus.ready_o === 1'b1) seen++;
      end
      chk("annul_no_ready", 64'(seen), 64'd0);
      do_op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, W + 1, "after_annul");

      // Asynchronous reset in the middle of an iteration
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      bus.start_i   = 1'b1;
      repeat (5) tick();
      rst = 1'b0;
      #1;
      chk("arst_ready",  {63'd0, bus.ready_o}, 64'd0);
      chk("arst_result", bus.result_o, 64'd0);
      chk("arst_busy",   {63'd0, bus.busy_o}, 64'd0);
      bus.start_i = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("arst_idle_busy", {63'd0, bus.busy_o}, 64'd0);
      do_op(32'd1, 32'd1, 1'b0, {32'h0, 32'h1}, W + 1, "after_arst");

      do_op(32'd5, 32'd9, 1'b0, {32'h5, 32'h0}, EARLY_LAT, "u5_9");
      do_op(32'hFFFFFFFD, 32'd5, 1'b1, {32'hFFFFFFFD, 32'h0}, EARLY_LAT, "s_m3_5");

      chk("queue_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
